writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Final pipeline stage, directly downstream of the memory stage.
- Holds the W pipeline register, loaded from the memory stage's m_* outputs.
- Owns the 15-entry x 64-bit architectural register file: two write ports (E, M) and two combinational read ports for decode.
- Produces processor status and a sticky halt indication.

Parameters:
NREGS, 15, architectural registers (IDs 0..14); ID 15 = RNONE (no register)
XLEN, 64, data width

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, synchronous, active-high
m_stat  in  3  memory-stage status (SAOK=1, SADR=2, SINS=3, SHLT=4)
m_icode  in  4  memory-stage icode
m_valE  in  64  ALU result
m_valM  in  64  memory read data
m_dstE  in  4  destination for valE
m_dstM  in  4  destination for valM
W_stall  in  1  hold W register
W_bubble  in  1  load bubble into W register
d_srcA  in  4  decode read port A register ID
d_srcB  in  4  decode read port B register ID
d_rvalA  out  64  register file read data A
d_rvalB  out  64  register file read data B
W_stat  out  3  registered status (for forwarding/control)
W_icode  out  4  registered icode
W_valE  out  64  registered valE (forwarding source)
W_valM  out  64  registered valM (forwarding source)
W_dstE  out  4  registered dstE
W_dstM  out  4  registered dstM
proc_stat  out  3  processor status (= W_stat, except SAOK for bubbles)
halted  out  1  sticky: W_stat left SAOK
retire_cnt  out  64  committed-instruction count (see Optional Feature)

Behaviour:
- Bubble value: stat=SAOK, icode=INOP(1), valE=valM=0, dstE=dstM=RNONE(15).
- Internal flags:
  - W_valid: 1 when the W register holds an instruction from the memory stage, 0 for a bubble.
  - W_new: 1 only in the first cycle after a load from the memory stage.
- Reset (rst=1 at posedge):
  - W register takes the bubble value; W_valid=0, W_new=0.
  - All 15 registers cleared to 0; halted=0; retire_cnt=0.
  - Reset overrides stall/bubble. Reset mid-run discards any in-flight W contents.
- W register update priority: rst > halted (hold) > W_stall (hold) > W_bubble (load bubble) > load m_*.
  - W_stall and W_bubble both high: stall wins.
  - Hold: W_new cleared. Load from m_*: W_valid=1, W_new=1.
- Register file writes at posedge, from current W outputs. Write enable requires W_valid=1, W_new=1, W_stat=SAOK, halted=0.
  - Port E writes W_valE to W_dstE when W_dstE != RNONE.
  - Port M writes W_valM to W_dstM when W_dstM != RNONE.
  - W_dstE == W_dstM (not RNONE): port M wins (popq %rsp semantics).
  - A stalled instruction is written once only, because W_new gates the write.
- Reads are combinational:
  - d_rvalX = reg[d_srcX]; RNONE returns 0.
  - Read of a register written the same cycle returns the old value. No internal bypass; decode forwards from W_valE/W_valM.
- halted:
  - Set at the posedge following any cycle with W_valid=1 and W_stat != SAOK (SADR/SINS/SHLT).
  - Cleared only by rst.
  - While halted: W register frozen, no register writes.
- proc_stat = W_stat when W_valid=1, else SAOK.
- Latency: m_* to W_* is 1 cycle; m_* to register-file visibility is 2 cycles.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined:
  - retire_cnt increments by 1 at each posedge where W_valid=1, W_new=1, W_stat=SAOK, halted=0.
  - The HALT instruction itself is not counted.
  - Wraps 2^64-1 -> 0. Reset clears it to 0.
- Undefined: counter logic absent; retire_cnt tied to 0.

Test Plan:
- Reset then load m_icode=IRRMOVQ, m_dstE=3, m_valE=0x1234, m_dstM=15 -> W_valE=0x1234 next cycle; d_srcA=3 reads 0x1234 one cycle later.
- Same-register dual write: m_dstE=4, m_dstM=4, m_valE=0x10, m_valM=0x20 (IPOPQ) -> reg4=0x20.
- W_stall=1 for 3 cycles with a valid write (dstE=2, valE=5) -> written once; retire_cnt +1 only (feature on); W_* held.
- W_bubble=1 with W_stall=0 -> W_icode=1, W_dstE=W_dstM=15, proc_stat=SAOK, no writes; W_bubble=1 with W_stall=1 -> hold.
- m_stat=SADR, dstE=5, valE=9 -> no write to reg5; halted=1 next cycle; later m_* ignored; rst clears halted and all registers to 0.
- Read-during-write: d_srcB=6 while W writes reg6 with 0xAA (old value 0x55) -> d_rvalB=0x55 that cycle, 0xAA the next; d_srcB=15 -> 0.

Source files
------------

// File: rtl/writeback_stage_if.sv
// ---------------------------------------------------------------------------
// writeback_stage_if
// Carries the memory stage's outputs (m_*) into the writeback stage. These
// signals are the pipeline payload that loads the W register.
//
// Signals:
//   m_stat  [2:0]      memory-stage status (SAOK=1, SADR=2, SINS=3, SHLT=4)
//   m_icode [3:0]      memory-stage instruction code
//   m_valE  [XLEN-1:0] ALU result
//   m_valM  [XLEN-1:0] memory read data
//   m_dstE  [3:0]      destination register for valE (15 = none)
//   m_dstM  [3:0]      destination register for valM (15 = none)
//
// Modports:
//   master - memory stage side, drives the payload
//   slave  - writeback stage side, consumes the payload
// ---------------------------------------------------------------------------
interface writeback_stage_if #(
  parameter int XLEN = 64
);

  logic [2:0]      m_stat;
  logic [3:0]      m_icode;
  logic [XLEN-1:0] m_valE;
  logic [XLEN-1:0] m_valM;
  logic [3:0]      m_dstE;
  logic [3:0]      m_dstM;

  modport master (
    output m_stat, m_icode, m_valE, m_valM, m_dstE, m_dstM
  );

  modport slave (
    input m_stat, m_icode, m_valE, m_valM, m_dstE, m_dstM
  );

endinterface

// File: rtl/writeback_stage.sv
// ---------------------------------------------------------------------------
// writeback_stage
// Final pipeline stage. Holds the W pipeline register loaded from the memory
// stage, owns the 15 x XLEN architectural register file (two write ports fed
// from W, two combinational read ports for decode), and reports processor
// status plus a sticky halt flag.
//
// Optional feature macro: WB_RETIRE_CNT_EN
//   defined   -> retire_cnt counts committed instructions
//   undefined -> retire_cnt is tied to 0
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   mIf (slave)           memory-stage payload m_stat/m_icode/m_valE/
//                         m_valM/m_dstE/m_dstM
//   W_stall, W_bubble     pipeline control for the W register
//   d_srcA, d_srcB        decode read register IDs (15 = none)
//   d_rvalA, d_rvalB      decode read data (old value on same-cycle write)
//   W_stat..W_dstM        registered W contents (forwarding sources)
//   proc_stat             W_stat for real instructions, SAOK for bubbles
//   halted                sticky, set once a non-SAOK instruction reaches W
//   retire_cnt            committed instruction count (see macro above)
// ---------------------------------------------------------------------------
module writeback_stage #(
  parameter int NREGS = 15,
  parameter int XLEN  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  writeback_stage_if.slave      mIf,
  input  logic                  W_stall,
  input  logic                  W_bubble,
  input  logic [3:0]            d_srcA,
  input  logic [3:0]            d_srcB,
  output logic [XLEN-1:0]       d_rvalA,
  output logic [XLEN-1:0]       d_rvalB,
  output logic [2:0]            W_stat,
  output logic [3:0]            W_icode,
  output logic [XLEN-1:0]       W_valE,
  output logic [XLEN-1:0]       W_valM,
  output logic [3:0]            W_dstE,
  output logic [3:0]            W_dstM,
  output logic [2:0]            proc_stat,
  output logic                  halted,
  output logic [XLEN-1:0]       retire_cnt
);

  localparam logic [2:0] SAOK  = 3'd1;
  localparam logic [3:0] INOP  = 4'd1;
  localparam logic [3:0] RNONE = 4'd15;

  // W pipeline register and its next-state values
  logic [2:0]      wStat_q,  wStat_d;
  logic [3:0]      wIcode_q, wIcode_d;
  logic [XLEN-1:0] wValE_q,  wValE_d;
  logic [XLEN-1:0] wValM_q,  wValM_d;
  logic [3:0]      wDstE_q,  wDstE_d;
  logic [3:0]      wDstM_q,  wDstM_d;
  logic            wValid_q, wValid_d;
  logic            wNew_q,   wNew_d;

  logic            halted_q;
  logic [XLEN-1:0] regs_q [NREGS];

  // An instruction commits exactly once: in its first cycle in W, only when
  // it completed normally and the processor has not stopped.
  logic commit;
  assign commit = wValid_q && wNew_q && (wStat_q == SAOK) && !halted_q;

  // W next state. Priority below reset: halted hold, stall hold, bubble,
  // then load. Any hold clears W_new so a held instruction is not rewritten.
  always_comb begin
    wStat_d  = wStat_q;
    wIcode_d = wIcode_q;
    wValE_d  = wValE_q;
    wValM_d  = wValM_q;
    wDstE_d  = wDstE_q;
    wDstM_d  = wDstM_q;
    wValid_d = wValid_q;
    wNew_d   = 1'b0;
    if (halted_q || W_stall) begin
      wNew_d = 1'b0;
    end else if (W_bubble) begin
      wStat_d  = SAOK;
      wIcode_d = INOP;
      wValE_d  = '0;
      wValM_d  = '0;
      wDstE_d  = RNONE;
      wDstM_d  = RNONE;
      wValid_d = 1'b0;
    end else begin
      wStat_d  = mIf.m_stat;
      wIcode_d = mIf.m_icode;
      wValE_d  = mIf.m_valE;
      wValM_d  = mIf.m_valM;
      wDstE_d  = mIf.m_dstE;
      wDstM_d  = mIf.m_dstM;
      wValid_d = 1'b1;
      wNew_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wStat_q  <= SAOK;
      wIcode_q <= INOP;
      wValE_q  <= '0;
      wValM_q  <= '0;
      wDstE_q  <= RNONE;
      wDstM_q  <= RNONE;
      wValid_q <= 1'b0;
      wNew_q   <= 1'b0;
    end else begin
      wStat_q  <= wStat_d;
      wIcode_q <= wIcode_d;
      wValE_q  <= wValE_d;
      wValM_q  <= wValM_d;
      wDstE_q  <= wDstE_d;
      wDstM_q  <= wDstM_d;
      wValid_q <= wValid_d;
      wNew_q   <= wNew_d;
    end
  end

  // Register file writes. Port M is written after port E so that when both
  // target the same register the memory value wins (popq %rsp).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (commit) begin
      if (wDstE_q != RNONE) begin
        regs_q[wDstE_q] <= wValE_q;
      end
      if (wDstM_q != RNONE) begin
        regs_q[wDstM_q] <= wValM_q;
      end
    end
  end

  // Sticky halt: set by any real instruction with an exceptional status.
  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q <= 1'b0;
    end else if (wValid_q && (wStat_q != SAOK)) begin
      halted_q <= 1'b1;
    end
  end

  // Decode reads see the pre-write contents; decode forwards from W itself.
  assign d_rvalA = (d_srcA != RNONE) ? regs_q[d_srcA] : '0;
  assign d_rvalB = (d_srcB != RNONE) ? regs_q[d_srcB] : '0;

  assign W_stat    = wStat_q;
  assign W_icode   = wIcode_q;
  assign W_valE    = wValE_q;
  assign W_valM    = wValM_q;
  assign W_dstE    = wDstE_q;
  assign W_dstM    = wDstM_q;
  assign proc_stat = wValid_q ? wStat_q : SAOK;
  assign halted    = halted_q;

`ifdef WB_RETIRE_CNT_EN
  localparam logic [XLEN-1:0] CNT_ONE = {{(XLEN-1){1'b0}}, 1'b1};

  logic [XLEN-1:0] retireCnt_q;

  // Counts the same events that commit, so HALT itself is never counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      retireCnt_q <= '0;
    end else if (commit) begin
      retireCnt_q <= retireCnt_q + CNT_ONE;
    end
  end

  assign retire_cnt = retireCnt_q;
`else
  assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// ---------------------------------------------------------------------------
// tb_writeback_stage
// Scoreboard bench for writeback_stage. The driver issues one stimulus per
// cycle, advances a behavioural model of the stage and pushes the expected
// post-edge view into a queue; an independent monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_writeback_stage;

  localparam logic [2:0] SAOK  = 3'd1;
  localparam logic [2:0] SADR  = 3'd2;
  localparam logic [3:0] RNONE = 4'd15;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        bubble;
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
  } stim_t;

  typedef struct {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [2:0]  procStat;
    logic        halted;
    logic [63:0] retire;
    logic [63:0] rvalA;
    logic [63:0] rvalB;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        W_stall, W_bubble;
  logic [3:0]  d_srcA, d_srcB;
  logic [63:0] d_rvalA, d_rvalB;
  logic [2:0]  W_stat;
  logic [3:0]  W_icode;
  logic [63:0] W_valE, W_valM;
  logic [3:0]  W_dstE, W_dstM;
  logic [2:0]  proc_stat;
  logic        halted;
  logic [63:0] retire_cnt;

  int checks = 0;
  int errors = 0;
  exp_t expQ[$];

  writeback_stage_if #(.XLEN(64)) mBus ();

  writeback_stage #(.NREGS(15), .XLEN(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .mIf        (mBus),
    .W_stall    (W_stall),
    .W_bubble   (W_bubble),
    .d_srcA     (d_srcA),
    .d_srcB     (d_srcB),
    .d_rvalA    (d_rvalA),
    .d_rvalB    (d_rvalB),
    .W_stat     (W_stat),
    .W_icode    (W_icode),
    .W_valE     (W_valE),
    .W_valM     (W_valM),
    .W_dstE     (W_dstE),
    .W_dstM     (W_dstM),
    .proc_stat  (proc_stat),
    .halted     (halted),
    .retire_cnt (retire_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: the architectural view of the stage. The W slot holds
  // either the last accepted instruction or a bubble; an instruction updates
  // the register file once, in the cycle after it arrives, if it is normal.
  logic [2:0]  mStat;
  logic [3:0]  mIcode;
  logic [63:0] mValE, mValM;
  logic [3:0]  mDstE, mDstM;
  logic        mIsInstr;
  logic        mFresh;
  logic        mHalted;
  logic [63:0] mRf [15];
  longint unsigned mRetired;

  task automatic modelStep(input stim_t s);
    bit writes;
    bit stopNow;
    if (s.rst) begin
      mStat = SAOK; mIcode = 4'd1; mValE = '0; mValM = '0;
      mDstE = RNONE; mDstM = RNONE;
      mIsInstr = 1'b0; mFresh = 1'b0; mHalted = 1'b0;
      for (int i = 0; i < 15; i++) mRf[i] = '0;
      mRetired = 0;
      return;
    end
    writes  = mIsInstr && mFresh && (mStat == SAOK) && !mHalted;
    stopNow = mHalted || (mIsInstr && mStat != SAOK);
    if (writes) begin
      if (mDstE != RNONE) mRf[mDstE] = mValE;
      if (mDstM != RNONE) mRf[mDstM] = mValM;
      mRetired = mRetired + 1;
    end
    if (mHalted || s.stall) begin
      mFresh = 1'b0;
    end else if (s.bubble) begin
      mStat = SAOK; mIcode = 4'd1; mValE = '0; mValM = '0;
      mDstE = RNONE; mDstM = RNONE;
      mIsInstr = 1'b0; mFresh = 1'b0;
    end else begin
      mStat = s.stat; mIcode = s.icode; mValE = s.valE; mValM = s.valM;
      mDstE = s.dstE; mDstM = s.dstM;
      mIsInstr = 1'b1; mFresh = 1'b1;
    end
    mHalted = stopNow;
  endtask

  function automatic logic [63:0] readReg(input logic [3:0] id);
    return (id == RNONE) ? 64'd0 : mRf[id];
  endfunction

  // Default stimulus: an ordinary NOP entering W, no register targets.
  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b0; s.stall = 1'b0; s.bubble = 1'b0;
    s.stat = SAOK; s.icode = 4'd1; s.valE = '0; s.valM = '0;
    s.dstE = RNONE; s.dstM = RNONE; s.srcA = RNONE; s.srcB = RNONE;
    return s;
  endfunction

  // Drive one cycle of stimulus and queue what the outputs must look like
  // once the following posedge has taken effect.
  task automatic applyStimulus(input stim_t s);
    exp_t e;
    @(negedge clk);
    rst      = s.rst;
    W_stall  = s.stall;
    W_bubble = s.bubble;
    mBus.m_stat  = s.stat;
    mBus.m_icode = s.icode;
    mBus.m_valE  = s.valE;
    mBus.m_valM  = s.valM;
    mBus.m_dstE  = s.dstE;
    mBus.m_dstM  = s.dstM;
    d_srcA = s.srcA;
    d_srcB = s.srcB;
    modelStep(s);
    e.stat     = mStat;
    e.icode    = mIcode;
    e.valE     = mValE;
    e.valM     = mValM;
    e.dstE     = mDstE;
    e.dstM     = mDstM;
    e.procStat = mIsInstr ? mStat : SAOK;
    e.halted   = mHalted;
`ifdef WB_RETIRE_CNT_EN
    e.retire   = mRetired;
`else
    e.retire   = 64'd0;
`endif
    e.rvalA    = readReg(s.srcA);
    e.rvalB    = readReg(s.srcB);
    expQ.push_back(e);
  endtask

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("W_stat",     {61'd0, W_stat},    {61'd0, e.stat});
    cmp("W_icode",    {60'd0, W_icode},   {60'd0, e.icode});
    cmp("W_valE",     W_valE,             e.valE);
    cmp("W_valM",     W_valM,             e.valM);
    cmp("W_dstE",     {60'd0, W_dstE},    {60'd0, e.dstE});
    cmp("W_dstM",     {60'd0, W_dstM},    {60'd0, e.dstM});
    cmp("proc_stat",  {61'd0, proc_stat}, {61'd0, e.procStat});
    cmp("halted",     {63'd0, halted},    {63'd0, e.halted});
    cmp("retire_cnt", retire_cnt,         e.retire);
    cmp("d_rvalA",    d_rvalA,            e.rvalA);
    cmp("d_rvalB",    d_rvalB,            e.rvalB);
  endtask

  // Monitor: one expected entry per edge, sampled just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s;
    rst = 1'b1; W_stall = 1'b0; W_bubble = 1'b0;
    d_srcA = RNONE; d_srcB = RNONE;
    mBus.m_stat = SAOK; mBus.m_icode = 4'd1; mBus.m_valE = '0;
    mBus.m_valM = '0; mBus.m_dstE = RNONE; mBus.m_dstM = RNONE;
    mIsInstr = 1'b0; mFresh = 1'b0; mHalted = 1'b0; mRetired = 0;

    $display("[TB] reset");
    s = idle(); s.rst = 1'b1;
    applyStimulus(s);
    applyStimulus(s);

    $display("[TB] rrmovq to reg3, visible two cycles later");
    s = idle(); s.icode = 4'd2; s.dstE = 4'd3; s.valE = 64'h1234; s.srcA = 4'd3;
    applyStimulus(s);
    s = idle(); s.srcA = 4'd3;
    applyStimulus(s);
    applyStimulus(s);

    $display("[TB] popq with dstE == dstM");
    s = idle(); s.icode = 4'hB; s.dstE = 4'd4; s.dstM = 4'd4;
    s.valE = 64'h10; s.valM = 64'h20; s.srcB = 4'd4;
    applyStimulus(s);
    s = idle(); s.srcB = 4'd4;
    applyStimulus(s);
    applyStimulus(s);

    $display("[TB] stall holds W and writes once");
    s = idle(); s.icode = 4'd6; s.dstE = 4'd2; s.valE = 64'd5; s.srcA = 4'd2;
    applyStimulus(s);
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.stall = 1'b1; s.dstE = 4'd7; s.valE = 64'd99; s.srcA = 4'd2; s.srcB = 4'd7;
      applyStimulus(s);
    end
    s = idle(); s.srcA = 4'd2; s.srcB = 4'd7;
    applyStimulus(s);

    $display("[TB] bubble, then bubble with stall");
    s = idle(); s.bubble = 1'b1; s.dstE = 4'd8; s.valE = 64'd1; s.srcA = 4'd8;
    applyStimulus(s);
    s = idle(); s.bubble = 1'b1; s.stall = 1'b1; s.dstE = 4'd8; s.valE = 64'd1; s.srcA = 4'd8;
    applyStimulus(s);
    s = idle(); s.srcA = 4'd8;
    applyStimulus(s);

    $display("[TB] read during write on reg6");
    s = idle(); s.icode = 4'd3; s.dstE = 4'd6; s.valE = 64'h55;
    applyStimulus(s);
    s = idle(); s.icode = 4'd3; s.dstE = 4'd6; s.valE = 64'hAA; s.srcB = 4'd6;
    applyStimulus(s);
    s = idle(); s.srcB = 4'd6;
    applyStimulus(s);
    applyStimulus(s);
    s = idle(); s.srcB = RNONE;
    applyStimulus(s);

    $display("[TB] address error halts the stage");
    s = idle(); s.stat = SADR; s.icode = 4'd5; s.dstE = 4'd5; s.valE = 64'd9; s.srcA = 4'd5;
    applyStimulus(s);
    for (int i = 0; i < 4; i++) begin
      s = idle(); s.icode = 4'd2; s.dstE = 4'd5; s.valE = 64'd77; s.srcA = 4'd5; s.srcB = 4'd3;
      applyStimulus(s);
    end
    s = idle(); s.rst = 1'b1; s.srcA = 4'd3; s.srcB = 4'd6;
    applyStimulus(s);
    s = idle(); s.srcA = 4'd3; s.srcB = 4'd6;
    applyStimulus(s);

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      s = idle();
      s.rst    = ($urandom_range(0, 59) == 0);
      s.stall  = ($urandom_range(0, 4) == 0);
      s.bubble = ($urandom_range(0, 4) == 0);
      s.stat   = ($urandom_range(0, 29) == 0) ? 3'($urandom_range(2, 4)) : SAOK;
      s.icode  = 4'($urandom_range(0, 11));
      s.valE   = {$urandom, $urandom};
      s.valM   = {$urandom, $urandom};
      s.dstE   = 4'($urandom_range(0, 15));
      s.dstM   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : RNONE;
      s.srcA   = 4'($urandom_range(0, 15));
      s.srcB   = 4'($urandom_range(0, 15));
      applyStimulus(s);
    end

    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain actual=%0d required=0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
